// File: rtl/segment_scan_ctrl_if.sv
// Word-addressed register bus: writes land on the accepting clock edge, read data is
// combinational from the current address, and the slave is always ready.
interface minibus_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/segment_scan_ctrl.sv
// Multiplexed seven-segment scanner: per-digit registers plus CTRL, a slot/phase counter,
// a per-slot shadow of the digit being shown, and brightness by phase gating.
module segment_scan_ctrl #(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic              clk,
  input  logic              nrst,
  minibus_slave_if.slave    _sif,
  output logic [DIGITS-1:0] seg_sel,
  output logic [7:0]        seg_data
);
  localparam int SUB_DIV = SCAN_DIV / 16;
  localparam int SUBW    = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IDXW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0]        dig_q [DIGITS];
  logic              en_q, en_d, dec_q, dec_d;
  logic [3:0]        bright_q, bright_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [SUBW-1:0]   sub_q, sub_d;
  logic [3:0]        phase_q, phase_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [7:0]        sh_pat_q, sh_pat_d;
  logic              sh_dec_q, sh_dec_d, sh_blank_q, sh_blank_d;
  logic [3:0]        sh_bright_q, sh_bright_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        data_q, data_d;
  logic              wr, run, lit, wdata_unused;
  logic [7:0]        pat;

  assign wr           = _sif.req & _sif.we;
  assign _sif.ready   = 1'b1;
  assign wdata_unused = ^_sif.wdata;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      always_ff @(posedge clk) begin
        if (!nrst) begin
          dig_q[gi] <= 8'h00;
        end else if (wr && _sif.addr == ADDR_WIDTH'(gi)) begin
          dig_q[gi] <= _sif.wdata[7:0];
        end
      end
    end
  endgenerate

  always_comb begin
    en_d     = en_q;
    dec_d    = dec_q;
    bright_d = bright_q;
    blank_d  = blank_q;
    if (wr && _sif.addr == ADDR_WIDTH'(DIGITS)) begin
      en_d     = _sif.wdata[0];
      dec_d    = _sif.wdata[1];
      bright_d = _sif.wdata[7:4];
      blank_d  = _sif.wdata[8 +: DIGITS];
    end
  end

  always_comb begin
    _sif.rdata = '0;
    for (int n = 0; n < DIGITS; n++) begin
      if (_sif.addr == ADDR_WIDTH'(n)) _sif.rdata[7:0] = dig_q[n];
    end
    if (_sif.addr == ADDR_WIDTH'(DIGITS)) begin
      _sif.rdata[0]           = en_q;
      _sif.rdata[1]           = dec_q;
      _sif.rdata[7:4]         = bright_q;
      _sif.rdata[8 +: DIGITS] = blank_q;
    end
  end

  // Requiring the next enable as well lets a disabling write blank the very next cycle.
  assign run = en_q & en_d;

  always_comb begin
    sub_d   = '0;
    phase_d = 4'd0;
    idx_d   = '0;
    if (run) begin
      idx_d = idx_q;
      if (sub_q == SUBW'(SUB_DIV - 1)) begin
        sub_d   = '0;
        phase_d = phase_q + 4'd1;
        if (phase_q == 4'd15) idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        sub_d   = sub_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_comb begin
    sh_pat_d    = sh_pat_q;
    sh_dec_d    = sh_dec_q;
    sh_bright_d = sh_bright_q;
    sh_blank_d  = sh_blank_q;
    if (en_q && sub_q == '0 && phase_q == 4'd0) begin
      sh_pat_d    = dig_q[idx_q];
      sh_dec_d    = dec_q;
      sh_bright_d = bright_q;
      sh_blank_d  = blank_q[idx_q];
    end
  end

  // Phase 0 is dark, so the shadow being loaded during it never reaches the outputs early.
  always_comb begin
    lit    = run && !sh_blank_q && phase_q != 4'd0 && phase_q <= sh_bright_q;
    pat    = sh_dec_q ? {sh_pat_q[7], hex7(sh_pat_q[3:0])} : sh_pat_q;
    sel_d  = (lit ? (DIGITS'(1) << idx_q) : '0) ^ SEL_OFF;
    data_d = (lit ? pat : 8'h00) ^ SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      en_q        <= 1'b0;
      dec_q       <= 1'b0;
      bright_q    <= 4'd0;
      blank_q     <= '0;
      sub_q       <= '0;
      phase_q     <= 4'd0;
      idx_q       <= '0;
      sh_pat_q    <= 8'h00;
      sh_dec_q    <= 1'b0;
      sh_bright_q <= 4'd0;
      sh_blank_q  <= 1'b0;
      sel_q       <= SEL_OFF;
      data_q      <= SEG_OFF;
    end else begin
      en_q        <= en_d;
      dec_q       <= dec_d;
      bright_q    <= bright_d;
      blank_q     <= blank_d;
      sub_q       <= sub_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      sh_pat_q    <= sh_pat_d;
      sh_dec_q    <= sh_dec_d;
      sh_bright_q <= sh_bright_d;
      sh_blank_q  <= sh_blank_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
    end
  end

  assign seg_sel  = sel_q;
  assign seg_data = data_q;
endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Directed bench for segment_scan_ctrl with DIGITS=6, SCAN_DIV=32, active-low outputs.
module tb_segment_scan_ctrl;
  logic       clk = 1'b0;
  logic       nrst;
  logic [5:0] seg_sel;
  logic [7:0] seg_data;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] pats [6];

  minibus_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) sif ();

  segment_scan_ctrl #(
    .DIGITS(6), .SCAN_DIV(32), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1),
    .DATA_WIDTH(32), .ADDR_WIDTH(4)
  ) dut (
    .clk(clk), .nrst(nrst), ._sif(sif), .seg_sel(seg_sel), .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    sif.req = 1'b1; sif.we = 1'b1; sif.addr = addr; sif.wdata = data;
    step();
    sif.req = 1'b0; sif.we = 1'b0;
    $display("write addr=%0d data=%08h", addr, data);
  endtask

  task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    sif.req = 1'b1; sif.we = 1'b0; sif.addr = addr;
    #1;
    check(tag, sif.rdata, exp);
    sif.req = 1'b0;
    $display("read  addr=%0d data=%08h", addr, sif.rdata);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"}, 32'(seg_sel), 32'h3F);
    check({tag, "_data"}, 32'(seg_data), 32'hFF);
  endtask

  // Enables with ctrl, then checks every cycle against the slot/phase timeline.
  // wkind: 0 none, 1 mid-slot digit write, 2 CTRL write clearing enable, 3 reset plus write.
  task automatic run(input logic [31:0] ctrl, input int ncyc, input int wkind, input int wk,
                     input logic [3:0] waddr, input logic [31:0] wdat);
    int rel, s, c, dig, ph;
    logic lit, dark;
    logic [7:0] pat;
    logic [3:0] bright;
    logic [5:0] blank;
    bright = ctrl[7:4];
    blank  = ctrl[13:8];
    bus_write(4'd6, ctrl);
    check_idle("run_start");
    for (int k = 2; k <= ncyc + 1; k++) begin
      if (k == wk) begin
        if (wkind == 3) nrst = 1'b0;
        sif.req = 1'b1; sif.we = 1'b1; sif.addr = waddr; sif.wdata = wdat;
      end
      step();
      if (k == wk) begin
        nrst = 1'b1; sif.req = 1'b0; sif.we = 1'b0;
        $display("mid-run kind=%0d addr=%0d data=%08h cycle=%0d", wkind, waddr, wdat, k);
      end
      if (wkind == 1 && k == wk + 1) bus_read(waddr, {24'h0, wdat[7:0]}, "rd_live");
      rel = k - 2; s = rel / 32; c = rel % 32; dig = s % 6; ph = c / 2;
      pat = pats[dig[2:0]];
      if (wkind == 1 && dig == int'(waddr) && 2 + 32 * s > wk) pat = wdat[7:0];
      dark = (wkind >= 2 && k >= wk);
      lit  = !dark && ph >= 1 && ph <= int'(bright) && !blank[dig[2:0]];
      check($sformatf("sel k=%0d", k), 32'(seg_sel),
            lit ? ((~(32'h1 << dig)) & 32'h3F) : 32'h3F);
      check($sformatf("data k=%0d", k), 32'(seg_data), lit ? {24'h0, ~pat} : 32'hFF);
    end
    $display("run ctrl=%08h cycles=%0d done", ctrl, ncyc);
  endtask

  initial begin
    nrst = 1'b0;
    sif.req = 1'b0; sif.we = 1'b0; sif.addr = 4'd0; sif.wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("in_reset");
    end
    nrst = 1'b1;
    check("ready", 32'(sif.ready), 32'h1);
    for (int a = 0; a < 8; a++) bus_read(4'(a), 32'h0, $sformatf("rst_rd%0d", a));
    for (int i = 0; i < 200; i++) begin
      step();
      check_idle("post_reset");
    end

    bus_write(4'd1, 32'hFFFF_FF00);
    bus_read(4'd1, 32'h0, "dig1_upper");
    bus_write(4'd7, 32'h0000_00FF);
    bus_read(4'd7, 32'h0, "unmapped7");
    bus_write(4'd0, 32'h0000_0085);
    bus_read(4'd0, 32'h85, "dig0");
    pats = '{8'hED, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
    run(32'h0000_C0FF, 200, 0, 0, 4'd0, 32'h0);
    bus_read(4'd6, 32'hF3, "ctrl_rb");

    bus_write(4'd6, 32'h0);
    check_idle("disable1");
    run(32'h0000_0043, 200, 0, 0, 4'd0, 32'h0);

    bus_write(4'd6, 32'h0);
    check_idle("disable2");
    bus_write(4'd0, 32'h11); bus_write(4'd1, 32'h22); bus_write(4'd2, 32'h44);
    bus_write(4'd3, 32'h88); bus_write(4'd4, 32'h5A); bus_write(4'd5, 32'hA5);
    pats = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h5A, 8'hA5};
    run(32'h0000_0491, 330, 1, 108, 4'd3, 32'h3C);

    bus_write(4'd6, 32'h0);
    pats = '{8'h11, 8'h22, 8'h44, 8'h3C, 8'h5A, 8'hA5};
    run(32'h0000_00F1, 100, 2, 46, 4'd6, 32'h0000_00F0);
    run(32'h0000_00F1, 70, 0, 0, 4'd0, 32'h0);

    bus_write(4'd6, 32'h0);
    pats = '{8'h06, 8'h5B, 8'h66, 8'h39, 8'h77, 8'hED};
    run(32'h0000_00F3, 200, 3, 138, 4'd0, 32'h55);
    for (int a = 0; a < 8; a++) bus_read(4'(a), 32'h0, $sformatf("post_rst_rd%0d", a));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/segment_scan_ctrl.md
SEGMENT_SCAN_CTRL -- requirements
Module: segment_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DIGITS, default 6, SHALL set the number of multiplexed digits (range 1..8).
REQ-003 Parameter SCAN_DIV, default 50000, SHALL set clocks per digit slot (multiple of 16, >=16).
REQ-004 Parameter SEL_ACTIVE_LOW, default 1, SHALL invert seg_sel when 1.
REQ-005 Parameter SEG_ACTIVE_LOW, default 1, SHALL invert seg_data when 1.
REQ-006 Port clk  input  1  system clock, all logic on rising edge.
REQ-007 Port nrst  input  1  synchronous active-low reset.
REQ-008 Port _sif  minibus_slave_if.slave  --  register access, DATA_WIDTH data, word-addressed.
REQ-009 Port seg_sel  output  DIGITS  digit select, one-hot when a digit is lit.
REQ-010 Port seg_data  output  8  segments a..g on bits 0..6, dp on bit 7.

Function
REQ-011 Register DIGn at word address n (n=0..DIGITS-1) SHALL hold 8 bits: raw pattern in raw mode, or [3:0] hex nibble plus [7] dp in decode mode.
REQ-012 Register CTRL at word address DIGITS SHALL hold: bit0 enable, bit1 decode, bits[7:4] brightness, bits[8+DIGITS-1:8] blank mask.
REQ-013 Bus writes SHALL update the addressed register in the accepting cycle; unwritten bits read back 0; unmapped addresses read 0 and ignore writes.
REQ-014 Bus reads SHALL return current register contents, never the shadow latch.
REQ-015 Slot counter SHALL count 0..SCAN_DIV-1 every clock while enable=1, then wrap to 0.
REQ-016 Digit index SHALL advance by 1 when slot counter wraps, going from DIGITS-1 to 0.
REQ-017 While enable=0, the slot counter and digit index SHALL hold at 0, and all outputs SHALL stay inactive.
REQ-018 Setting enable 0->1 SHALL start scanning at digit 0, counter 0, on the next cycle.
REQ-019 At counter=0, the block SHALL latch DIGn of the current index plus decode, brightness and blank bit into a shadow; mid-slot register writes SHALL NOT change outputs until the next slot.
REQ-020 Phase SHALL equal counter / (SCAN_DIV/16), range 0..15.
REQ-021 Phase 0 SHALL be a blanking guard, with all selects inactive.
REQ-022 The digit SHALL be lit only when 1 <= phase <= shadow brightness; brightness 0 SHALL mean always dark and 15 SHALL mean phases 1..15 lit.
REQ-023 A digit whose shadow blank bit is 1 SHALL stay dark for its whole slot.
REQ-024 Decode mode SHALL map nibble 0..F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 and OR dp into bit 7; raw mode SHALL pass DIGn unchanged.
REQ-025 When dark, seg_sel SHALL be all-inactive and seg_data SHALL be all segments off; polarity SHALL be applied last.
REQ-026 seg_sel and seg_data SHALL be registered, updating one clock after the counter and phase that produce them.
REQ-027 A CTRL write clearing enable mid-slot SHALL blank outputs one clock after the write cycle.

Reset
REQ-028 While nrst=0 at a clock edge: all DIGn=0, CTRL=0, counter=0, index=0, shadow=0.
REQ-029 While nrst=0 at a clock edge: seg_sel = all-inactive level (all 1s when SEL_ACTIVE_LOW=1).
REQ-030 While nrst=0 at a clock edge: seg_data = segments-off level (0xFF when SEG_ACTIVE_LOW=1).
REQ-031 Reset asserted mid-slot SHALL abort the scan, and outputs SHALL be inactive on the following cycle.
REQ-032 Reset SHALL have priority over a bus write in the same cycle.

Verification (DIGITS=6, SCAN_DIV=32, polarities 1)
REQ-033 Reset then read all addresses: every read = 0; seg_sel=0x3F and seg_data=0xFF held for 200 cycles.
REQ-034 Write DIG0=0x85, CTRL=0x0F3 (enable, decode, brightness 15): in slot 0, seg_sel=0x3E and seg_data=~0xED; dark for the 2 guard cycles; digits 1..5 show ~0x3F.
REQ-035 CTRL brightness=4: each slot has 2 dark cycles, 8 lit cycles, then 22 dark cycles; digit order is 0,1,..5,0 with a period of 192 cycles.
REQ-036 Raw mode, blank mask=0x04, DIG3 written mid-slot-3: digit 2 is never selected; slot 3 shows the old value and the next visit shows the new value.
REQ-037 Clear enable mid-slot, then set it again: outputs are inactive one cycle after the write, and the scan restarts at digit 0, counter 0.
REQ-038 Assert nrst during slot 4 while issuing a bus write: outputs are inactive next cycle, the write is discarded, and readback of all addresses is 0.
